// File: rtl/repetition_encoder_tx.sv
// repetition_encoder_tx
//   Serial transmitter that frames a DATA_WIDTH-bit payload as
//   START(0), DATA bits LSB first, [PARITY], STOP(1). Each symbol is held on
//   the line for REPEAT consecutive cycles so that a REPEAT-input majority
//   voter at the receiver can correct isolated sample errors.
//
// Parameters
//   DATA_WIDTH  payload bits per frame (1..32)
//   REPEAT      copies per symbol (odd, >= 3)
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   data_in     payload word, latched on acceptance
//   data_valid  producer offers data_in
//   data_ready  high only in IDLE; word accepted when valid & ready
//   tx_out      serial line, idle high (registered)
//   tx_active   high for every cycle of a frame (registered)
//   frame_done  one-cycle pulse on the final STOP cycle (registered)
//
// Build option
//   REP_TX_PARITY_EN  when defined, an even-parity symbol is inserted between
//                     the last DATA bit and STOP.
module repetition_encoder_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int REPEAT     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx_out,
  output logic                  tx_active,
  output logic                  frame_done
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int RW = $clog2(REPEAT);

  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);
  localparam logic [RW-1:0] REP_PRE  = RW'(REPEAT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef REP_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state_q;
  logic [RW-1:0]         rep_q;
  logic [BW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  tx_q;
  logic                  active_q;
  logic                  done_q;
  logic                  ready_q;
`ifdef REP_TX_PARITY_EN
  logic                  par_q;
`endif

  // The latched word is shifted right as bits go out, so the symbol on the
  // line is always data_q[0] and the next one is data_shift_d[0].
  logic [DATA_WIDTH-1:0] data_shift_d;
  logic                  sym_end_d;

  assign data_shift_d = data_q >> 1;
  assign sym_end_d    = (rep_q == REP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rep_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
`ifdef REP_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // ready comes up one edge after reset release, so a word offered
          // in that first cycle is not yet accepted.
          ready_q  <= 1'b1;
          tx_q     <= 1'b1;
          active_q <= 1'b0;
          if (ready_q && data_valid) begin
            data_q   <= data_in;
`ifdef REP_TX_PARITY_EN
            par_q    <= ^data_in;
`endif
            state_q  <= S_START;
            rep_q    <= '0;
            tx_q     <= 1'b0;
            active_q <= 1'b1;
            ready_q  <= 1'b0;
          end
        end

        S_START: begin
          if (sym_end_d) begin
            rep_q   <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= data_q[0];
          end else begin
            rep_q <= rep_q + 1'b1;
          end
        end

        S_DATA: begin
          if (sym_end_d) begin
            rep_q <= '0;
            if (bit_q == BIT_LAST) begin
              bit_q   <= '0;
`ifdef REP_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q  <= bit_q + 1'b1;
              data_q <= data_shift_d;
              tx_q   <= data_shift_d[0];
            end
          end else begin
            rep_q <= rep_q + 1'b1;
          end
        end

`ifdef REP_TX_PARITY_EN
        S_PARITY: begin
          if (sym_end_d) begin
            rep_q   <= '0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (sym_end_d) begin
            rep_q    <= '0;
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
          end else begin
            rep_q <= rep_q + 1'b1;
            // Registered pulse lands on the last STOP repetition.
            if (rep_q == REP_PRE) done_q <= 1'b1;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          rep_q    <= '0;
          bit_q    <= '0;
          tx_q     <= 1'b1;
          active_q <= 1'b0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = ready_q;
  assign tx_out     = tx_q;
  assign tx_active  = active_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_repetition_encoder_tx.sv
module tb_repetition_encoder_tx;

  localparam int DW  = 8;
  localparam int REP = 5;
`ifdef REP_TX_PARITY_EN
  localparam int NSYM  = DW + 3;
  localparam int SNSYM = 4;
`else
  localparam int NSYM  = DW + 2;
  localparam int SNSYM = 3;
`endif
  localparam int FLEN  = NSYM * REP;
  localparam int SREP  = 3;
  localparam int SFLEN = SNSYM * SREP;

  typedef struct {
    logic [DW-1:0]   data;
    logic [NSYM-1:0] syms;      // bit 0 = first symbol on the line
    int              done_cyc;
  } vec_t;

  vec_t vecs [7];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready, tx_out, tx_active, frame_done;

  logic [0:0]    s_data_in = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, s_tx, s_active, s_done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  repetition_encoder_tx #(.DATA_WIDTH(DW), .REPEAT(REP)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx_out(tx_out), .tx_active(tx_active),
    .frame_done(frame_done)
  );

  repetition_encoder_tx #(.DATA_WIDTH(1), .REPEAT(SREP)) u_small (
    .clk(clk), .rst(rst), .data_in(s_data_in), .data_valid(s_valid),
    .data_ready(s_ready), .tx_out(s_tx), .tx_active(s_active),
    .frame_done(s_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Offers one word (accepted at the next edge), checks every frame cycle,
  // then returns in the idle cycle that follows the frame with valid low.
  task automatic run_frame(input string tag, input logic [DW-1:0] d,
                           input logic [NSYM-1:0] syms, input int done_cyc,
                           input bit noise);
    int tx_err, act_err, rdy_err, done_cnt, done_at;
    tx_err = 0; act_err = 0; rdy_err = 0; done_cnt = 0; done_at = -1;
    check({tag, " ready_before"}, 32'(data_ready), 32'd1);
    data_in    = d;
    data_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= FLEN; c++) begin
      if (tx_out !== syms[(c-1)/REP]) tx_err++;
      if (tx_active !== 1'b1) act_err++;
      if (data_ready !== 1'b0) rdy_err++;
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (noise) data_in = DW'($urandom);
      else       data_valid = 1'b0;
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    check({tag, " tx_stream_errors"}, 32'(tx_err), 32'd0);
    check({tag, " active_errors"}, 32'(act_err), 32'd0);
    check({tag, " ready_in_frame_errors"}, 32'(rdy_err), 32'd0);
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " done_cycle"}, 32'(done_at), 32'(done_cyc));
    check({tag, " idle_tx"}, 32'(tx_out), 32'd1);
    check({tag, " idle_active"}, 32'(tx_active), 32'd0);
    check({tag, " idle_ready"}, 32'(data_ready), 32'd1);
    check({tag, " idle_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_words, frame_errs;
    logic [SFLEN-1:0] small_exp;
    int s_err, s_done_at;

`ifdef REP_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'b1_0_10100101_0, 55};
    vecs[1] = '{8'h00, 11'b1_0_00000000_0, 55};
    vecs[2] = '{8'hFF, 11'b1_0_11111111_0, 55};
    vecs[3] = '{8'h01, 11'b1_1_00000001_0, 55};
    vecs[4] = '{8'h3C, 11'b1_0_00111100_0, 55};
    vecs[5] = '{8'hC3, 11'b1_0_11000011_0, 55};
    vecs[6] = '{8'h5A, 11'b1_0_01011010_0, 55};
    small_exp = 12'b111_111_111_000;
`else
    vecs[0] = '{8'hA5, 10'b1_10100101_0, 50};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 50};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 50};
    vecs[3] = '{8'h01, 10'b1_00000001_0, 50};
    vecs[4] = '{8'h3C, 10'b1_00111100_0, 50};
    vecs[5] = '{8'hC3, 10'b1_11000011_0, 50};
    vecs[6] = '{8'h5A, 10'b1_01011010_0, 50};
    small_exp = 9'b111_111_000;
`endif

    // Reset state, with a word already offered to show it is ignored.
    data_in = 8'h77; data_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset tx_out", 32'(tx_out), 32'd1);
    check("reset tx_active", 32'(tx_active), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset data_ready", 32'(data_ready), 32'd0);
    data_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post-release ready still low", 32'(data_ready), 32'd0);
    @(posedge clk); #1;
    check("ready one edge after release", 32'(data_ready), 32'd1);
    check("idle tx high", 32'(tx_out), 32'd1);

    // Table-driven frames.
    for (int i = 0; i < 4; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].syms, vecs[i].done_cyc, 1'b0);

    // Valid held high, data_in scrambled mid-frame: back-to-back frames
    // with exactly one idle cycle between them.
    run_frame("b2b_3C", vecs[4].data, vecs[4].syms, vecs[4].done_cyc, 1'b1);
    run_frame("b2b_C3", vecs[5].data, vecs[5].syms, vecs[5].done_cyc, 1'b1);

    // Reset pulsed at cycle 20 of a frame of zeros.
    data_in = 8'h00; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("midframe tx_out before rst", 32'(tx_out), 32'd0);
    check("midframe active before rst", 32'(tx_active), 32'd1);
    rst = 1'b1;
    #1;
    check("async rst tx_out", 32'(tx_out), 32'd1);
    check("async rst tx_active", 32'(tx_active), 32'd0);
    check("async rst frame_done", 32'(frame_done), 32'd0);
    check("async rst data_ready", 32'(data_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst release ready low", 32'(data_ready), 32'd0);
    @(posedge clk); #1;
    check("rst release ready high", 32'(data_ready), 32'd1);
    check("rst release no resume", 32'(tx_active), 32'd0);
    run_frame("after_rst_5A", vecs[6].data, vecs[6].syms, vecs[6].done_cyc, 1'b0);

    // Loopback through a majority voter with one corrupted sample per symbol.
    bad_words = 0; frame_errs = 0;
    for (int w = 0; w < 256; w++) begin
      logic [DW-1:0]   word, dec;
      logic [FLEN-1:0] samp;
      int flip, ones;
      logic sym;
      word = DW'($urandom);
      dec = '0;
      data_in = word; data_valid = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
      for (int c = 0; c < FLEN; c++) begin
        samp[c] = tx_out;
        @(posedge clk); #1;
      end
      for (int s = 0; s < NSYM; s++) begin
        flip = int'($urandom_range(REP-1, 0));
        ones = 0;
        for (int k = 0; k < REP; k++)
          if (samp[s*REP+k] ^ (k == flip)) ones++;
        sym = (ones > REP/2);
        if (s >= 1 && s <= DW) dec[s-1] = sym;
        if (s == 0 && sym !== 1'b0) frame_errs++;
        if (s == NSYM-1 && sym !== 1'b1) frame_errs++;
`ifdef REP_TX_PARITY_EN
        if (s == NSYM-2 && sym !== ^word) frame_errs++;
`endif
      end
      if (dec !== word) bad_words++;
    end
    check("loopback bad words", 32'(bad_words), 32'd0);
    check("loopback framing errors", 32'(frame_errs), 32'd0);

    // DATA_WIDTH=1, REPEAT=3 instance sends a single 1.
    check("small ready", 32'(s_ready), 32'd1);
    s_err = 0; s_done_at = -1;
    s_data_in = 1'b1; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int c = 1; c <= SFLEN; c++) begin
      if (s_tx !== small_exp[c-1]) s_err++;
      if (s_active !== 1'b1) s_err++;
      if (s_done === 1'b1) s_done_at = c;
      @(posedge clk); #1;
    end
    check("small stream errors", 32'(s_err), 32'd0);
    check("small done cycle", 32'(s_done_at), 32'(SFLEN));
    check("small idle tx", 32'(s_tx), 32'd1);
    check("small idle ready", 32'(s_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
